// File: rtl/i2c_reg_slave.sv
`timescale 1ns/1ps
// i2c_reg_slave: oversampled I2C slave giving pointer-addressed access to a register bank.
// Ports:
//   clk, reset         system clock; synchronous active-low reset
//   en                 enables matching of new address bytes
//   my_addr            own 7-bit slave address
//   scl_i, sda_i       raw (asynchronous) pad inputs
//   sda_oe             1 pulls SDA low (open-drain pad)
//   reg_addr           current register pointer
//   reg_rdata          read data for reg_addr (combinational from the bank)
//   reg_wr, reg_wdata  one-clk write strobe and its data
//   busy               addressed transaction in progress
module i2c_reg_slave #(
    parameter  int unsigned ADDR_W = 7,
    parameter  int unsigned N_REGS = 16,
    parameter  int unsigned FILT   = 3,
    localparam int unsigned PTR_W  = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] my_addr,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [PTR_W-1:0]  reg_addr,
    input  logic [7:0]        reg_rdata,
    output logic              reg_wr,
    output logic [7:0]        reg_wdata,
    output logic              busy
);

    localparam int unsigned   CNT_W    = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [8:0]    N_REGS_9 = 9'(N_REGS);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_REGS - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, PTR, WR, ACK_D, RD, RD_ACK, RD_WAIT
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through the conditioning pipeline.
    logic [1:0]       sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [CNT_W-1:0] cnt_q [2];

    // Synchroniser plus run-length glitch filter; idle bus level is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q     <= {sda_i, scl_i};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_W'(FILT - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic             scl_rise, scl_fall, start_ev, stop_ev, sda_s;
    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr_inc;

    // Single-clk bus events on the filtered lines.
    assign scl_rise = filt_q[0] & ~filt_prev_q[0];
    assign scl_fall = ~filt_q[0] & filt_prev_q[0];
    assign start_ev = filt_q[0] & filt_prev_q[0] & filt_prev_q[1] & ~filt_q[1];
    assign stop_ev  = filt_q[0] & filt_prev_q[0] & ~filt_prev_q[1] & filt_q[1];
    assign sda_s    = filt_q[1];

    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             reg_wr_q, reg_wr_d;
    logic [7:0]       reg_wdata_q, reg_wdata_d;
    logic             busy_q, busy_d;
    logic             rw_q, rw_d;
    // In ACK states: 0 before the fall that starts the ACK, 1 while driving it.
    // In RD_ACK: 1 once the master ACK has been sampled.
    logic             phase_q, phase_d;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= '0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            reg_wr_q    <= reg_wr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        reg_wr_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        phase_d     = phase_q;

        // The pointer advances in the clk during which the write strobe is high.
        if (reg_wr_q) ptr_d = ptr_inc;

        if (stop_ev) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            bitcnt_d = '0;
            phase_d  = 1'b0;
        end else if (start_ev) begin
            state_d  = ADDR;
            sda_oe_d = 1'b0;
            bitcnt_d = '0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d  = rx_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (rx_byte[7:1] == 7'(my_addr) && en) begin
                            state_d = ACK_A;
                            busy_d  = 1'b1;
                            rw_d    = rx_byte[0];
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ACK_A: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        if (rw_q) begin
                            shift_d  = reg_rdata;
                            sda_oe_d = ~reg_rdata[7];
                            state_d  = RD;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = PTR;
                        end
                    end
                end
                PTR: if (scl_rise) begin
                    shift_d  = rx_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if ({1'b0, rx_byte} < N_REGS_9) begin
                            ptr_d   = rx_byte[PTR_W-1:0];
                            state_d = ACK_D;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                WR: if (scl_rise) begin
                    shift_d  = rx_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        reg_wr_d    = 1'b1;
                        reg_wdata_d = rx_byte;
                        state_d     = ACK_D;
                    end
                end
                ACK_D: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        state_d  = WR;
                    end
                end
                RD: if (scl_fall) begin
                    if (bitcnt_q == 3'd7) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = RD_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (!phase_q) begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ptr_d   = ptr_inc;
                                phase_d = 1'b1;
                            end else begin
                                state_d = RD_WAIT;
                            end
                        end
                    end else if (scl_fall) begin
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        shift_d  = reg_rdata;
                        sda_oe_d = ~reg_rdata[7];
                        state_d  = RD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = ptr_q;
    assign reg_wr    = reg_wr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
`timescale 1ns/1ps
// tb_i2c_reg_slave: bit-banged I2C master against i2c_reg_slave with a behavioural
// register-space model (array + pointer arithmetic) providing every expected value.
module tb_i2c_reg_slave;

    localparam int unsigned N_REGS = 16;
    localparam int          Q      = 10;   // quarter SCL period in clks

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic [6:0] my_addr = 7'h2A;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, reg_wr, busy;
    logic [3:0] reg_addr;
    logic [7:0] reg_rdata, reg_wdata;

    assign sda_line = sda_m & ~sda_oe;

    i2c_reg_slave #(.ADDR_W(7), .N_REGS(N_REGS), .FILT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .my_addr   (my_addr),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register bank seen by the DUT, plus logs of writes and sda_oe activity.
    logic [7:0] bank     [N_REGS];
    logic [7:0] init_val [N_REGS];
    logic       bank_load = 1'b0;
    int         obs_wq [$];
    int         oe_cnt = 0;

    assign reg_rdata = bank[reg_addr];

    always @(posedge clk) begin
        if (bank_load) begin
            for (int i = 0; i < int'(N_REGS); i++) bank[i] <= init_val[i];
        end else if (reg_wr) begin
            bank[reg_addr] <= reg_wdata;
            obs_wq.push_back(int'(reg_addr) * 256 + int'(reg_wdata));
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    // Reference model of the register space.
    logic [7:0] exp_regs [N_REGS];
    int         exp_ptr = 0;
    int         exp_wq [$];
    int         wchk = 0;
    logic [7:0] wdat [8];
    int         n_checks = 0;
    int         n_fail = 0;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One SCL clock starting just after SCL fell; optional 2-clk low glitch while SCL high.
    task automatic bit_io(input logic b, input logic glitch, output logic smp);
        tick(Q);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        smp = sda_line;
        if (glitch) begin
            sda_m = 1'b0;
            tick(2);
            sda_m = b;
            tick(Q - 2);
        end else begin
            tick(Q);
        end
        scl_m = 1'b0;
    endtask

    task automatic start_cond();
        sda_m = 1'b0;
        tick(2 * Q);
        scl_m = 1'b0;
    endtask

    task automatic rstart_cond();
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], (i == gbit), s);
        bit_io(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_io(~master_ack, 1'b0, s);
    endtask

    task automatic check_writes(input string tag);
        check({tag, " wr count"}, obs_wq.size(), exp_wq.size());
        for (int i = wchk; i < exp_wq.size() && i < obs_wq.size(); i++)
            check({tag, " wr addr/data"}, obs_wq[i], exp_wq[i]);
        wchk = exp_wq.size();
    endtask

    // Addressed write: pointer byte then n data bytes from wdat (no STOP).
    task automatic wr_txn(input string tag, input logic [7:0] ptr, input int n, input int gk);
        logic ack;
        start_cond();
        write_byte(8'h54, -1, ack);
        check({tag, " addr ack"}, ack, 1'b1);
        check({tag, " busy"}, busy, 1'b1);
        write_byte(ptr, -1, ack);
        check({tag, " ptr ack"}, ack, (ptr < 8'(N_REGS)) ? 1'b1 : 1'b0);
        if (ptr < 8'(N_REGS)) begin
            exp_ptr = int'(ptr);
            for (int k = 0; k < n; k++) begin
                write_byte(wdat[k], (k == gk) ? 4 : -1, ack);
                check({tag, " data ack"}, ack, 1'b1);
                exp_regs[exp_ptr] = wdat[k];
                exp_wq.push_back(exp_ptr * 256 + int'(wdat[k]));
                exp_ptr = (exp_ptr + 1) % int'(N_REGS);
            end
        end
    endtask

    // Set pointer, repeated START, read n bytes (ACK all but the last), STOP.
    task automatic rd_txn(input string tag, input logic [7:0] ptr, input int n);
        logic       ack;
        logic [7:0] d;
        int         oe0;
        start_cond();
        write_byte(8'h54, -1, ack);
        check({tag, " addr ack"}, ack, 1'b1);
        write_byte(ptr, -1, ack);
        check({tag, " ptr ack"}, ack, 1'b1);
        exp_ptr = int'(ptr);
        rstart_cond();
        write_byte(8'h55, -1, ack);
        check({tag, " rd addr ack"}, ack, 1'b1);
        for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, d);
            check({tag, " rd data"}, d, exp_regs[exp_ptr]);
            if (k < n - 1) exp_ptr = (exp_ptr + 1) % int'(N_REGS);
        end
        oe0 = oe_cnt;
        tick(3 * Q);
        check({tag, " released after nack"}, oe_cnt - oe0, 0);
        check({tag, " reg_addr"}, reg_addr, exp_ptr);
        stop_cond();
        check({tag, " busy after stop"}, busy, 1'b0);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] dbyte;
        int         oe0;

        for (int i = 0; i < int'(N_REGS); i++) begin
            init_val[i] = 8'($urandom);
            exp_regs[i] = init_val[i];
        end
        bank_load = 1'b1;
        reset = 1'b0;
        tick(5);
        bank_load = 1'b0;
        check("reset sda_oe", sda_oe, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset reg_wr", reg_wr, 1'b0);
        check("reset reg_addr", reg_addr, 4'd0);
        check("reset reg_wdata", reg_wdata, 8'd0);
        reset = 1'b1;
        tick(10);

        // Two writes from pointer 3.
        wdat[0] = 8'hA5;
        wdat[1] = 8'h5A;
        wr_txn("t1", 8'h03, 2, -1);
        stop_cond();
        check_writes("t1");
        check("t1 reg_addr", reg_addr, exp_ptr);
        check("t1 busy after stop", busy, 1'b0);

        // Pointer wrap from 15 to 0.
        wdat[0] = 8'h11;
        wdat[1] = 8'h22;
        wr_txn("t2", 8'h0F, 2, -1);
        stop_cond();
        check_writes("t2");
        check("t2 reg_addr", reg_addr, exp_ptr);

        // Read back two bytes from 5 with ACK then NACK.
        rd_txn("t3", 8'h05, 2);

        // Foreign address, then own address while disabled.
        for (int t = 0; t < 2; t++) begin
            en = (t == 0);
            oe0 = oe_cnt;
            start_cond();
            write_byte((t == 0) ? 8'h56 : 8'h54, -1, ack);
            check("ignored addr ack", ack, 1'b0);
            check("ignored addr sda_oe", oe_cnt - oe0, 0);
            check("ignored addr busy", busy, 1'b0);
            stop_cond();
            check_writes("ignored addr");
        end
        en = 1'b1;

        // Out-of-range pointer is refused and leaves the pointer alone.
        wr_txn("t6", 8'h10, 0, -1);
        stop_cond();
        check_writes("t6");
        check("t6 reg_addr", reg_addr, exp_ptr);

        // Short low glitch on SDA while SCL high inside a data byte.
        wdat[0] = 8'hFF;
        wdat[1] = 8'($urandom);
        wr_txn("t7", 8'h09, 2, 0);
        stop_cond();
        check_writes("t7");
        rd_txn("t7r", 8'h09, 2);

        // Reset in the middle of a write data byte.
        dbyte = 8'hC3;
        start_cond();
        write_byte(8'h54, -1, ack);
        check("t8 addr ack", ack, 1'b1);
        write_byte(8'h07, -1, ack);
        check("t8 ptr ack", ack, 1'b1);
        for (int i = 7; i >= 4; i--) bit_io(dbyte[i], 1'b0, s);
        check("t8 busy before reset", busy, 1'b1);
        reset = 1'b0;
        tick(1);
        check("t8 sda_oe", sda_oe, 1'b0);
        check("t8 busy", busy, 1'b0);
        check("t8 reg_addr", reg_addr, 4'd0);
        reset = 1'b1;
        exp_ptr = 0;
        oe0 = oe_cnt;
        for (int i = 3; i >= 0; i--) bit_io(dbyte[i], 1'b0, s);
        bit_io(1'b1, 1'b0, s);
        check("t8 no ack", s, 1'b1);
        check("t8 sda_oe quiet", oe_cnt - oe0, 0);
        stop_cond();
        check_writes("t8");
        check("t8 reg_addr after", reg_addr, exp_ptr);

        // Random writes and read-backs against the model.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) wdat[k] = 8'($urandom);
            wr_txn("rand wr", 8'($urandom_range(0, 15)), n, -1);
            stop_cond();
            check_writes("rand wr");
            check("rand wr reg_addr", reg_addr, exp_ptr);
            rd_txn("rand rd", 8'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
